// File: rtl/seq_alu_if.sv
// Operand/result bundle between a requester and seq_alu; clk/rst_f stay outside.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             flush;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic [3:0]       stat;
  logic             busy;
  logic             done;

  modport master (
    output start, flush, opcode, a, b,
    input  result, stat, busy, done
  );

  modport slave (
    input  start, flush, opcode, a, b,
    output result, stat, busy, done
  );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle arithmetic/logic ops, bit-serial shifts and rotates
// (one position per cycle), registered result and {C,V,N,Z} status.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input logic      clk,
  input logic      rst_f,
  seq_alu_if.slave bus
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_NOT = 4'h4,
    OP_OR  = 4'h5, OP_AND = 4'h6, OP_XOR = 4'h7, OP_RTR = 4'h8,
    OP_RTL = 4'h9, OP_SHR = 4'hA, OP_SHL = 4'hB
  } op_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_op;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_stat;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_wr;
  logic [WIDTH-1:0] w_step;
  logic             w_is_shift;

  assign w_sum      = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff     = {1'b0, r_a} - {1'b0, r_b};
  assign w_is_shift = bus.opcode inside {OP_RTR, OP_RTL, OP_SHR, OP_SHL};

  // w_wr low means NOP/unused opcode: completion pulse only, result/stat hold.
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_wr  = 1'b1;
    case (r_op)
      OP_ADD: begin
        w_res = w_sum[MSB:0];
        w_c   = w_sum[WIDTH];
        w_v   = (r_a[MSB] == r_b[MSB]) && (w_sum[MSB] != r_a[MSB]);
      end
      OP_SUB: begin
        w_res = w_diff[MSB:0];
        w_c   = w_diff[WIDTH];
        w_v   = (r_a[MSB] != r_b[MSB]) && (w_diff[MSB] != r_a[MSB]);
      end
      OP_NOT:  w_res = ~r_a;
      OP_OR:   w_res = r_a | r_b;
      OP_AND:  w_res = r_a & r_b;
      OP_XOR:  w_res = r_a ^ r_b;
      default: w_wr  = 1'b0;
    endcase
  end

  always_comb begin
    w_step = r_a;
    case (r_op)
      OP_SHR:  w_step = {1'b0, r_a[MSB:1]};
      OP_SHL:  w_step = {r_a[MSB-1:0], 1'b0};
      OP_RTR:  w_step = {r_a[0], r_a[MSB:1]};
      OP_RTL:  w_step = {r_a[MSB-1:0], r_a[MSB]};
      default: w_step = r_a;
    endcase
  end

  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_stat   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a  <= bus.a;
            r_b  <= bus.b;
            r_op <= bus.opcode;
            if (w_is_shift) begin
              r_cnt   <= bus.b[SHW-1:0];
              r_busy  <= 1'b1;
              r_state <= SHIFT;
            end else begin
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b1;
          r_state <= IDLE;
          if (w_wr) begin
            r_result <= w_res;
            r_stat   <= {w_c, w_v, w_res[MSB], ~|w_res};
          end
        end
        SHIFT: begin
          // Flush is tested before the terminal count so it wins on a tie.
          if (bus.flush) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (r_cnt == '0) begin
            r_result <= r_a;
            r_stat   <= {2'b00, r_a[MSB], ~|r_a};
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end else begin
            r_a   <= w_step;
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.result = r_result;
  assign bus.stat   = r_stat;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: vector table for the 32-bit instance plus
// hand-written flush/reset sequences and an 8-bit instance.
module tb_seq_alu;

  logic clk = 1'b0;
  logic rst_f;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(32)) u_if ();
  seq_alu_if #(.WIDTH(8))  u_if8 ();

  seq_alu #(.WIDTH(32), .SHW(5)) u_dut (
    .clk   (clk),
    .rst_f (rst_f),
    .bus   (u_if)
  );

  seq_alu #(.WIDTH(8), .SHW(3)) u_dut8 (
    .clk   (clk),
    .rst_f (rst_f),
    .bus   (u_if8)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  st;
    int          lat;
  } vec_t;

  vec_t tv [20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run32(input vec_t v, input string nm);
    int   n;
    logic exp_busy;
    exp_busy = (v.op >= 4'h8) && (v.op <= 4'hB);
    u_if.start  = 1'b1;
    u_if.opcode = v.op;
    u_if.a      = v.a;
    u_if.b      = v.b;
    tick();
    u_if.start = 1'b0;
    chk($sformatf("%s busy", nm), 32'(u_if.busy), 32'(exp_busy));
    n = 0;
    while (u_if.done !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    chk($sformatf("%s latency", nm), 32'(n), 32'(v.lat));
    chk($sformatf("%s result", nm), u_if.result, v.res);
    chk($sformatf("%s stat", nm), 32'(u_if.stat), 32'(v.st));
    chk($sformatf("%s busy_end", nm), 32'(u_if.busy), 32'd0);
    tick();
    chk($sformatf("%s done_once", nm), 32'(u_if.done), 32'd0);
  endtask

  task automatic run8(input vec_t v, input string nm);
    int n;
    u_if8.start  = 1'b1;
    u_if8.opcode = v.op;
    u_if8.a      = v.a[7:0];
    u_if8.b      = v.b[7:0];
    tick();
    u_if8.start = 1'b0;
    n = 0;
    while (u_if8.done !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    chk($sformatf("%s latency", nm), 32'(n), 32'(v.lat));
    chk($sformatf("%s result", nm), 32'(u_if8.result), v.res);
    chk($sformatf("%s stat", nm), 32'(u_if8.stat), 32'(v.st));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int   dones;
    vec_t v;

    tv[0]  = '{4'h1, 32'h00000001, 32'h00000001, 32'h00000002, 4'b0000, 1};
    tv[1]  = '{4'h2, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b1010, 1};
    tv[2]  = '{4'h2, 32'h00000001, 32'h00000001, 32'h00000000, 4'b0001, 1};
    tv[3]  = '{4'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 4'b1100, 1};
    tv[4]  = '{4'h0, 32'h12345678, 32'h00000001, 32'h7FFFFFFF, 4'b1100, 1};
    tv[5]  = '{4'hE, 32'h00000000, 32'h00000000, 32'h7FFFFFFF, 4'b1100, 1};
    tv[6]  = '{4'h6, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0010, 1};
    tv[7]  = '{4'h5, 32'h0000000F, 32'h000000F0, 32'h000000FF, 4'b0000, 1};
    tv[8]  = '{4'h7, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 4'b0001, 1};
    tv[9]  = '{4'h4, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 4'b0010, 1};
    tv[10] = '{4'h3, 32'h11111111, 32'h22222222, 32'hFFFFFFFF, 4'b0010, 1};
    tv[11] = '{4'h1, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0110, 1};
    tv[12] = '{4'h2, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0100, 1};
    tv[13] = '{4'hB, 32'h80000000, 32'h00000001, 32'h00000000, 4'b0001, 2};
    tv[14] = '{4'hB, 32'h00000002, 32'h00000002, 32'h00000008, 4'b0000, 3};
    tv[15] = '{4'h9, 32'hFF000008, 32'h00000001, 32'hFE000011, 4'b0010, 2};
    tv[16] = '{4'h8, 32'h00000001, 32'h00000001, 32'h80000000, 4'b0010, 2};
    tv[17] = '{4'hA, 32'h80000000, 32'h00000000, 32'h80000000, 4'b0010, 1};
    tv[18] = '{4'hB, 32'h00000001, 32'h00000021, 32'h00000002, 4'b0000, 2};
    tv[19] = '{4'hA, 32'hF0000000, 32'h00000004, 32'h0F000000, 4'b0000, 5};

    rst_f = 1'b1;
    u_if.start = 1'b0;  u_if.flush = 1'b0;  u_if.opcode = '0;  u_if.a = '0;  u_if.b = '0;
    u_if8.start = 1'b0; u_if8.flush = 1'b0; u_if8.opcode = '0; u_if8.a = '0; u_if8.b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset result", u_if.result, 32'h0);
    chk("reset stat", 32'(u_if.stat), 32'h0);
    chk("reset busy", 32'(u_if.busy), 32'h0);
    chk("reset done", 32'(u_if.done), 32'h0);
    rst_f = 1'b0;

    for (int i = 0; i < 20; i++) run32(tv[i], $sformatf("vec%0d", i));

    // Flush mid-shift, with a start attempt while busy.
    u_if.start = 1'b1; u_if.opcode = 4'hA; u_if.a = 32'hFFFFFFFF; u_if.b = 32'd31;
    tick();
    u_if.start = 1'b0;
    chk("flush busy", 32'(u_if.busy), 32'd1);
    tick();
    u_if.start = 1'b1; u_if.opcode = 4'h1; u_if.a = 32'h1; u_if.b = 32'h1;
    tick();
    u_if.start = 1'b0;
    tick();
    u_if.flush = 1'b1;
    tick();
    u_if.flush = 1'b0;
    chk("flush busy_clr", 32'(u_if.busy), 32'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (u_if.done === 1'b1) dones++;
      tick();
    end
    chk("flush no_done", 32'(dones), 32'd0);
    chk("flush result_hold", u_if.result, 32'h0F000000);
    chk("flush stat_hold", 32'(u_if.stat), 32'h0);

    // Flush in IDLE is ignored.
    u_if.flush = 1'b1;
    v = '{4'h1, 32'h00000005, 32'h00000006, 32'h0000000B, 4'b0000, 1};
    run32(v, "idle_flush_add");
    u_if.flush = 1'b0;

    // Flush on the same edge as the terminal count.
    u_if.start = 1'b1; u_if.opcode = 4'hB; u_if.a = 32'h1; u_if.b = 32'd2;
    tick();
    u_if.start = 1'b0;
    tick();
    tick();
    u_if.flush = 1'b1;
    tick();
    u_if.flush = 1'b0;
    chk("tie done", 32'(u_if.done), 32'd0);
    chk("tie busy", 32'(u_if.busy), 32'd0);
    chk("tie result", u_if.result, 32'h0000000B);
    tick();
    chk("tie done_later", 32'(u_if.done), 32'd0);

    // Asynchronous reset mid-shift.
    u_if.start = 1'b1; u_if.opcode = 4'hB; u_if.a = 32'h3; u_if.b = 32'd10;
    tick();
    u_if.start = 1'b0;
    tick();
    tick();
    rst_f = 1'b1;
    #1;
    chk("areset result", u_if.result, 32'h0);
    chk("areset stat", 32'(u_if.stat), 32'h0);
    chk("areset busy", 32'(u_if.busy), 32'h0);
    chk("areset done", 32'(u_if.done), 32'h0);
    #2;
    rst_f = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (u_if.done === 1'b1) dones++;
    end
    chk("areset no_done", 32'(dones), 32'd0);

    // First start is taken on the first edge after reset release.
    #2;
    rst_f = 1'b1;
    #2;
    rst_f = 1'b0;
    v = '{4'h1, 32'h00000003, 32'h00000004, 32'h00000007, 4'b0000, 1};
    run32(v, "post_reset_add");

    v = '{4'h1, 32'h0000007F, 32'h00000001, 32'h00000080, 4'b0110, 1};
    run8(v, "w8 add");
    v = '{4'hB, 32'h00000001, 32'h00000009, 32'h00000002, 4'b0000, 2};
    run8(v, "w8 shl");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
